// File: rtl/cpu_debug_ocimem.sv
// Debug OCI RAM: a JTAG command path and a CPU slave port share one synchronous RAM.
// JTAG reads take 2 cycles, CPU reads take 2 cycles, a one-deep pending register absorbs busy-time strobes.
module cpu_debug_ocimem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic              cpu_debugaccess,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              ocimem_busy,
    output logic              cmd_overrun
);

    typedef enum logic [1:0] {IDLE, JRD, CRD} state_t;
    typedef enum logic [1:0] {C_NONE, C_A, C_NA, C_B} cmd_t;

    logic [31:0]       mem [0:2**ADDR_W-1];
    logic [31:0]       ram_q;
    state_t            state;
    logic [ADDR_W-1:0] mon_a_reg;
    logic              pend_vld;
    cmd_t              pend_type;
    logic [37:0]       pend_jdo;

    cmd_t              new_cmd;
    cmd_t              cur_cmd;
    logic [37:0]       cur_jdo;
    logic [ADDR_W-1:0] cur_addr;
    logic              multi;
    logic              is_idle;
    logic              serve_pend;
    logic              serve_new;
    logic              jtag_rd;
    logic              cpu_rd_go;
    logic              cpu_wr_go;
    logic              drop_new;
    logic              new_to_pend;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [31:0]       ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic              unused_jdo;

    assign unused_jdo = ^{cur_jdo[37:36], cur_jdo[2:0]};

    always_comb begin
        new_cmd = C_NONE;
        if (take_action_ocimem_b)         new_cmd = C_B;
        else if (take_action_ocimem_a)    new_cmd = C_A;
        else if (take_no_action_ocimem_a) new_cmd = C_NA;
        multi = ({1'b0, take_action_ocimem_a} + {1'b0, take_no_action_ocimem_a}
                 + {1'b0, take_action_ocimem_b}) > 2'd1;

        is_idle    = (state == IDLE);
        serve_pend = is_idle && pend_vld;
        serve_new  = is_idle && !pend_vld && (new_cmd != C_NONE);
        cur_cmd    = serve_pend ? pend_type : (serve_new ? new_cmd : C_NONE);
        cur_jdo    = serve_pend ? pend_jdo : jdo;
        cur_addr   = cur_jdo[17 +: ADDR_W];
        jtag_rd    = (cur_cmd == C_NA) || ((cur_cmd == C_A) && cur_jdo[35]);

        // JTAG always wins; a simultaneous CPU read+write serves the read first
        cpu_rd_go  = is_idle && (cur_cmd == C_NONE) && cpu_read;
        cpu_wr_go  = is_idle && (cur_cmd == C_NONE) && cpu_write && !cpu_read;

        // Queued strobes are older, so a new strobe never overtakes a full pending slot
        drop_new    = (new_cmd != C_NONE) && pend_vld;
        new_to_pend = (new_cmd != C_NONE) && !is_idle && !pend_vld;

        ram_we    = 1'b0;
        ram_waddr = mon_a_reg;
        ram_wdata = cur_jdo[34:3];
        if (cur_cmd == C_B) begin
            ram_we = 1'b1;
        end else if (cpu_wr_go && cpu_debugaccess) begin
            ram_we    = 1'b1;
            ram_waddr = cpu_address;
            ram_wdata = cpu_writedata;
        end

        ram_raddr = cpu_address;
        if (cur_cmd == C_A)       ram_raddr = cur_addr;
        else if (cur_cmd == C_NA) ram_raddr = mon_a_reg;
    end

    always_ff @(posedge clk) begin
        if (reset_n && ram_we)
            mem[ram_waddr] <= ram_wdata;
        ram_q <= mem[ram_raddr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            pend_vld      <= 1'b0;
            pend_type     <= C_NONE;
            pend_jdo      <= '0;
            cmd_overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (jtag_rd) begin
                        monitor_ready <= 1'b0;
                        state         <= JRD;
                        if (cur_cmd == C_A) mon_a_reg <= cur_addr;
                    end else if (cur_cmd == C_A) begin
                        mon_a_reg <= cur_addr;
                    end else if (cur_cmd == C_B) begin
                        mon_a_reg <= mon_a_reg + ADDR_W'(1);
                    end else if (cpu_rd_go) begin
                        state <= CRD;
                    end
                end
                JRD: begin
                    MonDReg       <= ram_q;
                    monitor_ready <= 1'b1;
                    mon_a_reg     <= mon_a_reg + ADDR_W'(1);
                    state         <= IDLE;
                end
                CRD:     state <= IDLE;
                default: state <= IDLE;
            endcase

            if (serve_pend) begin
                pend_vld <= 1'b0;
            end else if (new_to_pend) begin
                pend_vld  <= 1'b1;
                pend_type <= new_cmd;
                pend_jdo  <= jdo;
            end

            if (multi || drop_new)
                cmd_overrun <= 1'b1;
        end
    end

    assign cpu_readdata    = (state == CRD) ? ram_q : '0;
    assign cpu_waitrequest = !(reset_n && ((state == CRD) || cpu_wr_go));
    assign ocimem_busy     = (state != IDLE) || pend_vld;

endmodule
